// File: rtl/dc_stage_pkg.sv
// Shared widths, stall indices, size patterns and bus layouts for the data-cache request stage.
package dc_stage_pkg;

  localparam int EX_TO_DC_WD  = 108;
  localparam int DC_TO_MEM_WD = 76;
  localparam int STALL_WD     = 6;
  localparam int STALL_DC     = 4;
  localparam int STALL_MEM    = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [3:0] SIZE_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_HALF = 4'b0011;
  localparam logic [3:0] SIZE_WORD = 4'b1111;
  localparam logic [3:0] SIZE_LOAD = 4'b0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } ex_to_dc_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } dc_to_mem_t;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_DONE = 1'b1
  } req_state_e;

endpackage

// File: rtl/dc_store_align.sv
// Byte-lane alignment of a store: write strobe, replicated write data and,
// under DC_MISALIGN_CHK_EN, the misaligned-access flag.
module dc_store_align
  import dc_stage_pkg::*;
(
  input  logic [3:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
`ifdef DC_MISALIGN_CHK_EN
  output logic        misalign,
`endif
  output logic [31:0] wdata
);

  // Bits shifted past lane 3 fall off; loads (0000) stay 0000.
  assign wstrb = size << offset;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    wdata = store_data;
    case (size)
      SIZE_BYTE: wdata = {4{store_data[7:0]}};
      SIZE_HALF: wdata = {2{store_data[15:0]}};
      default:   wdata = store_data;
    endcase
  end

`ifdef DC_MISALIGN_CHK_EN
  assign misalign = ((size == SIZE_HALF) && offset[0]) ||
                    ((size == SIZE_WORD) && (offset != 2'b00));
`endif

endmodule

// File: rtl/dc_stage.sv
// Data-cache request stage: pipeline register plus a one-shot request FSM.
// Optional misaligned-access suppression is built when DC_MISALIGN_CHK_EN is defined.
module dc_stage
  import dc_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_DC_WD-1:0]  ex_to_dc_bus,
  input  logic                    data_sram_addr_ok,
  output logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
  output logic                    data_sram_req,
  output logic                    data_sram_wr,
  output logic [3:0]              data_sram_wstrb,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
`ifdef DC_MISALIGN_CHK_EN
  output logic                    dc_misalign,
`endif
  output logic                    stallreq_for_dc
);

  ex_to_dc_t  stage_q;
  dc_to_mem_t mem_out;
  req_state_e state_q, state_d;
  logic       stop_dc, stop_mem, bubble, load, reg_update, misalign;
  logic       unused_stall;

  // Only the own and downstream stall bits matter here.
  assign unused_stall = ^stall[STALL_DC-1:0];

  assign stop_dc    = (stall[STALL_DC] == STOP);
  assign stop_mem   = (stall[STALL_MEM] == STOP);
  assign bubble     = stop_dc && !stop_mem;
  assign load       = (stall[STALL_DC] == NO_STOP);
  assign reg_update = flush || bubble || load;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst)         stage_q <= '0;
    else if (flush)  stage_q <= '0;
    else if (bubble) stage_q <= '0;
    else if (load)   stage_q <= ex_to_dc_bus;
  end

  dc_store_align u_align (
    .size       (stage_q.data_ram_wen),
    .offset     (stage_q.alu_result[1:0]),
    .store_data (stage_q.store_data),
    .wstrb      (data_sram_wstrb),
`ifdef DC_MISALIGN_CHK_EN
    .misalign   (misalign),
`endif
    .wdata      (data_sram_wdata)
  );

`ifndef DC_MISALIGN_CHK_EN
  assign misalign = 1'b0;
`else
  assign dc_misalign = misalign && stage_q.data_ram_en;
`endif

  // Once accepted, the access must not be re-issued until a new instruction occupies the stage.
  always_ff @(posedge clk) begin
    if (rst) state_q <= REQ_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (reg_update)
      state_d = REQ_IDLE;
    else if ((state_q == REQ_IDLE) && data_sram_req && data_sram_addr_ok && stop_dc)
      state_d = REQ_DONE;
  end

  assign data_sram_req   = (state_q == REQ_IDLE) && stage_q.data_ram_en && !misalign;
  assign stallreq_for_dc = data_sram_req && !data_sram_addr_ok;
  assign data_sram_addr  = stage_q.alu_result;
  assign data_sram_wr    = (stage_q.data_ram_wen != SIZE_LOAD);

  always_comb begin
    mem_out.pc           = stage_q.pc;
    mem_out.data_ram_en  = stage_q.data_ram_en && !misalign;
    mem_out.data_ram_wen = misalign ? 4'b0000 : data_sram_wstrb;
    mem_out.sel_rf_res   = stage_q.sel_rf_res;
    mem_out.rf_we        = stage_q.rf_we;
    mem_out.rf_waddr     = stage_q.rf_waddr;
    mem_out.alu_result   = stage_q.alu_result;
  end

  assign dc_to_mem_bus = mem_out;

endmodule

// File: tb/tb_dc_stage.sv
// Self-checking bench for dc_stage: directed scenarios followed by random traffic
// compared against a behavioural model of the stage occupant and its acceptance.
module tb_dc_stage;
  import dc_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, flush, data_sram_addr_ok;
  logic [STALL_WD-1:0]     stall;
  logic [EX_TO_DC_WD-1:0]  ex_to_dc_bus;
  logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus;
  logic                    data_sram_req, data_sram_wr, stallreq_for_dc;
  logic [3:0]              data_sram_wstrb;
  logic [31:0]             data_sram_addr, data_sram_wdata;
`ifdef DC_MISALIGN_CHK_EN
  logic                    dc_misalign;
`endif

  int checks = 0;
  int failures = 0;

  ex_to_dc_t  occ;
  bit         acc;
  dc_to_mem_t seen;
  int         pulses;

  dc_stage dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .stall             (stall),
    .ex_to_dc_bus      (ex_to_dc_bus),
    .data_sram_addr_ok (data_sram_addr_ok),
    .dc_to_mem_bus     (dc_to_mem_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
`ifdef DC_MISALIGN_CHK_EN
    .dc_misalign       (dc_misalign),
`endif
    .stallreq_for_dc   (stallreq_for_dc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic int nbytes();
    return $countones(occ.data_ram_wen);
  endfunction

  function automatic bit model_mis();
`ifdef DC_MISALIGN_CHK_EN
    return ((nbytes() == 2) && (occ.alu_result % 2 != 0)) ||
           ((nbytes() == 4) && (occ.alu_result % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_req();
    return occ.data_ram_en && !acc && !model_mis();
  endfunction

  function automatic logic [3:0] model_wstrb();
    int m;
    m = int'(occ.data_ram_wen) << (occ.alu_result % 4);
    return 4'(m & 15);
  endfunction

  function automatic logic [31:0] model_wdata();
    logic [31:0] w;
    int span;
    span = (nbytes() == 0) ? 4 : nbytes();
    for (int i = 0; i < 4; i++) w[8*i +: 8] = occ.store_data[8*(i % span) +: 8];
    return w;
  endfunction

  function automatic logic [DC_TO_MEM_WD-1:0] model_bus();
    return {occ.pc, occ.data_ram_en && !model_mis(), model_mis() ? 4'b0000 : model_wstrb(),
            occ.sel_rf_res, occ.rf_we, occ.rf_waddr, occ.alu_result};
  endfunction

  function automatic ex_to_dc_t make_instr(logic [3:0] size, logic [31:0] addr, logic [31:0] sd);
    ex_to_dc_t t;
    t.pc           = $urandom;
    t.data_ram_en  = 1'b1;
    t.data_ram_wen = size;
    t.sel_rf_res   = (size == SIZE_LOAD);
    t.rf_we        = (size == SIZE_LOAD);
    t.rf_waddr     = 5'($urandom);
    t.alu_result   = addr;
    t.store_data   = sd;
    return t;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("req", data_sram_req, model_req());
    check("stallreq", stallreq_for_dc, model_req() && !data_sram_addr_ok);
    check("addr", data_sram_addr, occ.alu_result);
    check("wr", data_sram_wr, occ.data_ram_wen != 4'b0000);
    check("wstrb", data_sram_wstrb, model_wstrb());
    check("wdata", data_sram_wdata, model_wdata());
    check("bus", dc_to_mem_bus, model_bus());
`ifdef DC_MISALIGN_CHK_EN
    check("misalign", dc_misalign, model_mis() && occ.data_ram_en);
`endif
  endtask

  task automatic settle();
    @(negedge clk);
    seen = dc_to_mem_bus;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic clock_edge();
    ex_to_dc_t nxt;
    bit nacc;
    if (rst || flush) begin
      nxt = '0; nacc = 1'b0;
    end else if (stall[4] == NO_STOP) begin
      nxt = ex_to_dc_bus; nacc = 1'b0;
    end else if (stall[5] == NO_STOP) begin
      nxt = '0; nacc = 1'b0;
    end else begin
      nxt = occ; nacc = acc || (model_req() && data_sram_addr_ok);
    end
    @(posedge clk);
    #1;
    occ = nxt;
    acc = nacc;
  endtask

  task automatic cycle();
    settle();
    check_all();
    clock_edge();
  endtask

  task automatic set_stall(input logic s_dc, input logic s_mem);
    stall = '0;
    stall[4] = s_dc;
    stall[5] = s_mem;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0; ex_to_dc_bus = '0; data_sram_addr_ok = 1'b0;
    occ = '0; acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a concurrent addr_ok that must not matter.
    data_sram_addr_ok = 1'b1;
    settle();
    check_all();
    check("rst_req", data_sram_req, 1'b0);
    check("rst_bus", dc_to_mem_bus, '0);
    clock_edge();
    rst = 1'b0; data_sram_addr_ok = 1'b0;

    // sb at 0x103: strobe on lane 3, byte replicated, single-cycle request.
    ex_to_dc_bus = make_instr(SIZE_BYTE, 32'h0000_0103, 32'h0000_00AB);
    set_stall(NO_STOP, NO_STOP);
    cycle();
    ex_to_dc_bus = '0; data_sram_addr_ok = 1'b1;
    settle();
    check_all();
    check("sb_wstrb", data_sram_wstrb, 4'b1000);
    check("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
    check("sb_req", data_sram_req, 1'b1);
    check("sb_stallreq", stallreq_for_dc, 1'b0);
    clock_edge();
    data_sram_addr_ok = 1'b0;
    settle();
    check("sb_req_once", data_sram_req, 1'b0);
    clock_edge();

    // lw at 0x200 waits three cycles for acceptance.
    ex_to_dc_bus = make_instr(SIZE_LOAD, 32'h0000_0200, $urandom);
    cycle();
    ex_to_dc_bus = '0;
    set_stall(STOP, STOP);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_all();
      check("lw_req_wait", data_sram_req, 1'b1);
      check("lw_stallreq_wait", stallreq_for_dc, 1'b1);
      clock_edge();
    end
    data_sram_addr_ok = 1'b1;
    set_stall(NO_STOP, NO_STOP);
    settle();
    check_all();
    check("lw_stallreq_acc", stallreq_for_dc, 1'b0);
    check("lw_fwd_wen", seen.data_ram_wen, 4'b0000);
    clock_edge();
    data_sram_addr_ok = 1'b0;
    cycle();

    // sw accepted while the stage is held: exactly one request pulse.
    ex_to_dc_bus = make_instr(SIZE_WORD, 32'h0000_0204, $urandom);
    cycle();
    ex_to_dc_bus = '0;
    set_stall(STOP, STOP);
    data_sram_addr_ok = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_all();
      pulses += int'(data_sram_req);
      clock_edge();
    end
    check("sw_pulses", pulses, 1);
    set_stall(NO_STOP, NO_STOP);
    data_sram_addr_ok = 1'b0;
    cycle();

    // Flush cancels a pending request with no retry.
    ex_to_dc_bus = make_instr(SIZE_WORD, 32'h0000_0208, $urandom);
    cycle();
    ex_to_dc_bus = '0;
    set_stall(STOP, STOP);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_all();
      check("flush_req", data_sram_req, 1'b0);
      check("flush_bus", dc_to_mem_bus, '0);
      clock_edge();
    end

    // Own stop with downstream running inserts a zero bubble.
    set_stall(NO_STOP, NO_STOP);
    ex_to_dc_bus = make_instr(SIZE_LOAD, 32'h0000_0300, $urandom);
    cycle();
    ex_to_dc_bus = make_instr(SIZE_WORD, 32'h0000_0304, $urandom);
    set_stall(STOP, NO_STOP);
    data_sram_addr_ok = 1'b1;
    cycle();
    set_stall(STOP, STOP);
    data_sram_addr_ok = 1'b0;
    settle();
    check_all();
    check("bubble_bus", dc_to_mem_bus, '0);
    clock_edge();

    // Reset beats a concurrent acceptance.
    set_stall(NO_STOP, NO_STOP);
    ex_to_dc_bus = make_instr(SIZE_HALF, 32'h0000_0402, $urandom);
    cycle();
    ex_to_dc_bus = '0;
    set_stall(STOP, STOP);
    data_sram_addr_ok = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    data_sram_addr_ok = 1'b0;
    settle();
    check_all();
    check("rst_acc_bus", dc_to_mem_bus, '0);
    check("rst_acc_req", data_sram_req, 1'b0);
    clock_edge();

    // sh at odd address.
    set_stall(NO_STOP, NO_STOP);
    ex_to_dc_bus = make_instr(SIZE_HALF, 32'h0000_0101, 32'h1234_5678);
    cycle();
    ex_to_dc_bus = '0;
    set_stall(STOP, STOP);
    settle();
    check_all();
`ifdef DC_MISALIGN_CHK_EN
    check("mis_req", data_sram_req, 1'b0);
    check("mis_flag", dc_misalign, 1'b1);
    check("mis_fwd_wen", seen.data_ram_wen, 4'b0000);
`else
    check("sh_odd_req", data_sram_req, 1'b1);
    check("sh_odd_wstrb", data_sram_wstrb, 4'b0110);
    check("sh_odd_wdata", data_sram_wdata, 32'h5678_5678);
`endif
    clock_edge();
    set_stall(NO_STOP, NO_STOP);
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] size;
      ex_to_dc_t t;
      case ($urandom_range(0, 3))
        0:       size = SIZE_BYTE;
        1:       size = SIZE_HALF;
        2:       size = SIZE_WORD;
        default: size = SIZE_LOAD;
      endcase
      t = make_instr(size, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        t.data_ram_en = 1'b0;
        t.data_ram_wen = 4'b0000;
      end
      ex_to_dc_bus = t;
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      stall = STALL_WD'($urandom);
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
